uc_multiciclo: RTL and testbench

UC_MULTICICLO -- requirements
Module: uc_multiciclo

---
 rtl/uc_multiciclo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for a MIPS-style datapath.
// Moore FSM: datapath controls decode from the registered state, with
// mem_ready only gating the fetch-side IR/PC writes. The memory states
// (FETCH, MEMRD, MEMWR) wait on mem_ready and are guarded by a wait
// counter. The unit traps on a stalled access or an unknown opcode.
module uc_multiciclo #(
  parameter int MEM_HS      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               aluSrcA,
  output logic               regWrite,
  output logic               regDst,
  output logic [1:0]         pcSrc,
  output logic [1:0]         aluSrcB,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic               mem_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  // ALU control classes before zero-extension to ALUOP_W
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Raw state bits are kept as a plain vector so the unused codes 13-15
  // are representable and can be recovered from.
  logic [3:0] stateReg;
  state_t     cur;
  state_t     stateNext;
  logic [7:0] waitCnt;
  logic [7:0] waitCntNext;
  logic       illegalReg;
  logic       timeoutReg;
  logic       setIllegal;
  logic       setTimeout;
  logic       ready;
  logic       isMemState;
  logic       waitExpired;
  logic [1:0] aluClass;

  assign cur = state_t'(stateReg);

  // Without handshake the memory always answers in one cycle.
  assign ready = (MEM_HS == 0) ? 1'b1 : mem_ready;

  assign isMemState = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);

  // A stalled access gives up once the counter reaches the limit; a
  // ready strobe in that same cycle still completes the access.
  assign waitExpired = (MEM_HS != 0) && !mem_ready && (waitCnt == TIMEOUT_LIMIT);

  // Next-state selection and sticky-flag set requests
  always_comb begin
    stateNext  = cur;
    setIllegal = 1'b0;
    setTimeout = 1'b0;
    case (cur)
      FETCH: begin
        if (ready) begin
          stateNext = DECODE;
        end else if (waitExpired) begin
          stateNext  = TRAP;
          setTimeout = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:      stateNext = EXEC;
          OP_LW, OP_SW:  stateNext = MEMADR;
          OP_BEQ:        stateNext = BRANCH;
          OP_ADDI:       stateNext = ADDIEX;
          OP_J:          stateNext = JUMP;
          default: begin
            stateNext  = TRAP;
            setIllegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        // opcode is re-sampled here; anything but lw/sw is treated as illegal
        if (opcode == OP_LW) begin
          stateNext = MEMRD;
        end else if (opcode == OP_SW) begin
          stateNext = MEMWR;
        end else begin
          stateNext  = TRAP;
          setIllegal = 1'b1;
        end
      end
      MEMRD: begin
        if (ready) begin
          stateNext = MEMWB;
        end else if (waitExpired) begin
          stateNext  = TRAP;
          setTimeout = 1'b1;
        end
      end
      MEMWB:  stateNext = FETCH;
      MEMWR: begin
        if (ready) begin
          stateNext = FETCH;
        end else if (waitExpired) begin
          stateNext  = TRAP;
          setTimeout = 1'b1;
        end
      end
      EXEC:   stateNext = ALUWB;
      ALUWB:  stateNext = FETCH;
      BRANCH: stateNext = FETCH;
      ADDIEX: stateNext = ADDIWB;
      ADDIWB: stateNext = FETCH;
      JUMP:   stateNext = FETCH;
      TRAP:   stateNext = TRAP;
      default: stateNext = TRAP;
    endcase
  end

  // Wait counter: cleared on every state change so each memory state
  // starts from zero, counts only stalled memory cycles.
  always_comb begin
    waitCntNext = waitCnt;
    if (stateNext != cur) begin
      waitCntNext = 8'd0;
    end else if (isMemState && !ready) begin
      waitCntNext = waitCnt + 8'd1;
    end
  end

  // Moore output decode; every control defaults low
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memtoReg    = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    pcSrc       = 2'b00;
    aluSrcB     = 2'b00;
    aluClass    = ALU_ADD;
    case (cur)
      FETCH: begin
        memRead  = 1'b1;
        aluSrcB  = 2'b01;
        aluClass = ALU_ADD;
        pcSrc    = 2'b00;
        // IR and PC only latch in the cycle the memory delivers
        irWrite  = ready;
        pcWrite  = ready;
      end
      DECODE: begin
        aluSrcB  = 2'b11;
        aluClass = ALU_ADD;
      end
      MEMADR: begin
        aluSrcA  = 1'b1;
        aluSrcB  = 2'b10;
        aluClass = ALU_ADD;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEMWB: begin
        memtoReg = 1'b1;
        regWrite = 1'b1;
        regDst   = 1'b0;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      EXEC: begin
        aluSrcA  = 1'b1;
        aluSrcB  = 2'b00;
        aluClass = ALU_FUNCT;
      end
      ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
        memtoReg = 1'b0;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluSrcB     = 2'b00;
        aluClass    = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b01;
      end
      ADDIEX: begin
        aluSrcA  = 1'b1;
        aluSrcB  = 2'b10;
        aluClass = ALU_ADD;
      end
      ADDIWB: begin
        regDst   = 1'b0;
        regWrite = 1'b1;
        memtoReg = 1'b0;
      end
      JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b10;
      end
      default: begin
        // TRAP and the unused codes drive nothing
      end
    endcase
  end

  assign aluOp = ALUOP_W'(aluClass);

  // State, wait counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= 4'(FETCH);
      waitCnt    <= 8'd0;
      illegalReg <= 1'b0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg <= 4'(stateNext);
      waitCnt  <= waitCntNext;
      if (setIllegal) begin
        illegalReg <= 1'b1;
      end
      if (setTimeout) begin
        timeoutReg <= 1'b1;
      end
    end
  end

  assign state       = stateReg;
  assign illegal_op  = illegalReg;
  assign mem_timeout = timeoutReg;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: instance A runs without handshake,
// instance B with handshake and a short timeout. The stimulus process
// queues the expected state/controls/flags for each cycle; the monitor
// pops and compares on the falling edge.
module tb_uc_multiciclo;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       memReady;

  logic pcWriteA, pcWriteCondA, iorDA, memReadA, memWriteA, irWriteA;
  logic memtoRegA, aluSrcAA, regWriteA, regDstA, illegalA, timeoutA;
  logic [1:0] pcSrcA, aluSrcBA, aluOpA;
  logic [3:0] stateA;

  logic pcWriteB, pcWriteCondB, iorDB, memReadB, memWriteB, irWriteB;
  logic memtoRegB, aluSrcAB, regWriteB, regDstB, illegalB, timeoutB;
  logic [1:0] pcSrcB, aluSrcBB, aluOpB;
  logic [3:0] stateB;

  uc_multiciclo #(.MEM_HS(0), .MEM_TIMEOUT(15), .ALUOP_W(2)) uA (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReady),
    .pcWrite(pcWriteA), .pcWriteCond(pcWriteCondA), .iorD(iorDA),
    .memRead(memReadA), .memWrite(memWriteA), .irWrite(irWriteA),
    .memtoReg(memtoRegA), .aluSrcA(aluSrcAA), .regWrite(regWriteA),
    .regDst(regDstA), .pcSrc(pcSrcA), .aluSrcB(aluSrcBA), .aluOp(aluOpA),
    .state(stateA), .illegal_op(illegalA), .mem_timeout(timeoutA)
  );

  uc_multiciclo #(.MEM_HS(1), .MEM_TIMEOUT(4), .ALUOP_W(2)) uB (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReady),
    .pcWrite(pcWriteB), .pcWriteCond(pcWriteCondB), .iorD(iorDB),
    .memRead(memReadB), .memWrite(memWriteB), .irWrite(irWriteB),
    .memtoReg(memtoRegB), .aluSrcA(aluSrcAB), .regWrite(regWriteB),
    .regDst(regDstB), .pcSrc(pcSrcB), .aluSrcB(aluSrcBB), .aluOp(aluOpB),
    .state(stateB), .illegal_op(illegalB), .mem_timeout(timeoutB)
  );

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memtoReg,aluSrcA,
  //  regWrite,regDst,pcSrc[1:0],aluSrcB[1:0],aluOp[1:0]}
  logic [15:0] ctlA, ctlB;
  assign ctlA = {pcWriteA, pcWriteCondA, iorDA, memReadA, memWriteA, irWriteA,
                 memtoRegA, aluSrcAA, regWriteA, regDstA, pcSrcA, aluSrcBA, aluOpA};
  assign ctlB = {pcWriteB, pcWriteCondB, iorDB, memReadB, memWriteB, irWriteB,
                 memtoRegB, aluSrcAB, regWriteB, regDstB, pcSrcB, aluSrcBB, aluOpB};

  typedef struct {
    int          inst;
    string       name;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t expQ[$];
  int   nCmp = 0;
  int   nBad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived control word per state; r is the effective mem_ready.
  function automatic logic [15:0] fc(input logic [3:0] s, input logic r);
    case (s)
      4'd0:    fc = r ? 16'h9404 : 16'h1004;
      4'd1:    fc = 16'h000C;
      4'd2:    fc = 16'h0108;
      4'd3:    fc = 16'h3000;
      4'd4:    fc = 16'h0280;
      4'd5:    fc = 16'h2800;
      4'd6:    fc = 16'h0102;
      4'd7:    fc = 16'h00C0;
      4'd8:    fc = 16'h4111;
      4'd9:    fc = 16'h0108;
      4'd10:   fc = 16'h0080;
      4'd11:   fc = 16'h8020;
      default: fc = 16'h0000;
    endcase
  endfunction

  // Monitor: one expectation per falling edge
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  gs;
    logic [15:0] gc;
    logic        gi, gt;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.inst == 0) begin
        gs = stateA; gc = ctlA; gi = illegalA; gt = timeoutA;
      end else begin
        gs = stateB; gc = ctlB; gi = illegalB; gt = timeoutB;
      end
      nCmp++;
      if (gs !== e.st || gc !== e.ctl || gi !== e.ill || gt !== e.to) begin
        nBad++;
        $display("FAIL %s: got state=%0d ctl=%h ill=%b to=%b, expected state=%0d ctl=%h ill=%b to=%b",
                 e.name, gs, gc, gi, gt, e.st, e.ctl, e.ill, e.to);
      end
    end
  end

  // Apply inputs at posedge+1, queue the expectation for the coming
  // falling edge, then advance one cycle.
  task automatic step(input int inst, input string nm, input logic [5:0] opc,
                      input logic rdy, input logic [3:0] st, input logic [15:0] ctl,
                      input logic ill, input logic to);
    exp_t e;
    opcode   = opc;
    memReady = rdy;
    e.inst = inst; e.name = nm; e.st = st; e.ctl = ctl; e.ill = ill; e.to = to;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Instance A instruction walk; seq holds state codes, first in low nibble.
  task automatic runA(input string nm, input logic [5:0] opc,
                      input logic [19:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      step(0, nm, opc, 1'b0, seq[4*i +: 4], fc(seq[4*i +: 4], 1'b1), 1'b0, 1'b0);
    end
  endtask

  task automatic pulseRst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = 6'b000000;
    memReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: FETCH decode, fetch writes follow effective ready
    step(0, "rstA", 6'b000000, 1'b0, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);
    step(1, "rstB", 6'b000000, 1'b0, 4'd0, fc(4'd0, 1'b0), 1'b0, 1'b0);
    rst_n = 1'b1;

    // No-handshake instruction sequences
    runA("rtype", 6'b000000, 20'h07610, 4);
    runA("lw",    6'b100011, 20'h43210, 5);
    runA("sw",    6'b101011, 20'h05210, 4);
    runA("beq",   6'b000100, 20'h00810, 3);
    runA("addi",  6'b001000, 20'h0A910, 4);
    runA("j",     6'b000010, 20'h00B10, 3);
    step(0, "retFetch", 6'b000000, 1'b0, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);

    // Illegal opcode traps with sticky flag
    step(0, "illDecode", 6'b111111, 1'b0, 4'd1, fc(4'd1, 1'b1), 1'b0, 1'b0);
    step(0, "illTrap",   6'b000000, 1'b0, 4'd12, 16'h0000, 1'b1, 1'b0);
    step(0, "illSticky", 6'b100011, 1'b0, 4'd12, 16'h0000, 1'b1, 1'b0);
    pulseRst();
    step(0, "illCleared", 6'b000000, 1'b0, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);

    // Unused state code recovers to TRAP
    force uA.stateReg = 4'd14;
    #1;
    release uA.stateReg;
    step(0, "code14",     6'b000000, 1'b0, 4'd14, 16'h0000, 1'b0, 1'b0);
    step(0, "code14Trap", 6'b000000, 1'b0, 4'd12, 16'h0000, 1'b0, 1'b0);

    // Handshake lw with three stalled MEMRD cycles
    pulseRst();
    step(1, "lwFetch",  6'b100011, 1'b1, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);
    step(1, "lwDecode", 6'b100011, 1'b0, 4'd1, fc(4'd1, 1'b0), 1'b0, 1'b0);
    step(1, "lwMemAdr", 6'b100011, 1'b0, 4'd2, fc(4'd2, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, "lwMemRdWait", 6'b100011, 1'b0, 4'd3, fc(4'd3, 1'b0), 1'b0, 1'b0);
    end
    step(1, "lwMemRdDone", 6'b100011, 1'b1, 4'd3, fc(4'd3, 1'b1), 1'b0, 1'b0);
    step(1, "lwMemWb",     6'b100011, 1'b0, 4'd4, fc(4'd4, 1'b0), 1'b0, 1'b0);
    step(1, "lwBack",      6'b100011, 1'b0, 4'd0, fc(4'd0, 1'b0), 1'b0, 1'b0);

    // Fetch timeout: five stalled cycles then TRAP
    pulseRst();
    for (int i = 0; i < 5; i++) begin
      step(1, "toFetchWait", 6'b000000, 1'b0, 4'd0, fc(4'd0, 1'b0), 1'b0, 1'b0);
    end
    step(1, "toTrap",   6'b000000, 1'b0, 4'd12, 16'h0000, 1'b0, 1'b1);
    step(1, "toSticky", 6'b000000, 1'b1, 4'd12, 16'h0000, 1'b0, 1'b1);

    // Ready on the last allowed cycle wins over the timeout
    pulseRst();
    for (int i = 0; i < 4; i++) begin
      step(1, "edgeFetchWait", 6'b000010, 1'b0, 4'd0, fc(4'd0, 1'b0), 1'b0, 1'b0);
    end
    step(1, "edgeFetchDone", 6'b000010, 1'b1, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);
    step(1, "edgeDecode",    6'b000010, 1'b0, 4'd1, fc(4'd1, 1'b0), 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stalled store
    pulseRst();
    step(1, "swFetch",  6'b101011, 1'b1, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);
    step(1, "swDecode", 6'b101011, 1'b0, 4'd1, fc(4'd1, 1'b0), 1'b0, 1'b0);
    step(1, "swMemAdr", 6'b101011, 1'b0, 4'd2, fc(4'd2, 1'b0), 1'b0, 1'b0);
    step(1, "swMemWr",  6'b101011, 1'b0, 4'd5, fc(4'd5, 1'b0), 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1, "swRstMid", 6'b101011, 1'b0, 4'd0, fc(4'd0, 1'b0), 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1, "postRstFetch",  6'b000100, 1'b1, 4'd0, fc(4'd0, 1'b1), 1'b0, 1'b0);
    step(1, "postRstDecode", 6'b000100, 1'b0, 4'd1, fc(4'd1, 1'b0), 1'b0, 1'b0);
    step(1, "postRstBranch", 6'b000100, 1'b0, 4'd8, fc(4'd8, 1'b0), 1'b0, 1'b0);

    // Every queued expectation must have been consumed
    @(posedge clk);
    #1;
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
